mont_seq: RTL
=============

# mont_seq

Sequencer for the 514-bit carry-save Montgomery datapath (`mpadder`). It latches operand b and runs three steps in order:
- N_BITS bit-serial iterations (add A, conditionally add M, shift right);
- a six-phase carry-propagate reduction;
- repeated six-phase subtraction passes of M until the datapath flags underflow.

It drives every control input of the adder and selects which operand feeds the adder's `in_a`.

## Interface
- N_BITS, 512, number of Montgomery iterations (bits of b consumed, LSB first); legal 1..512
- MAX_PASS, 8, subtraction passes allowed before error
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  begin operation; sampled only in IDLE
- b_in  in  512  multiplier operand, latched on accepted start
- c_zero  in  1  adder LSB of carry-save value (sum^carry bit 0)
- sub_done  in  1  adder subtract-finished flag
- busy  out  1  high from the cycle after accepted start through FIN
- done  out  1  one-cycle pulse in FIN
- err  out  1  pulses with done if MAX_PASS exhausted
- opsel  out  2  in_a source: 00 zero, 01 A, 10 M, 11 two's-complement of M
- add_clear_n  out  1  active-low clear of adder accumulator, ANDed with resetn by wrapper
- add_enable_c  out  1  adder enableC
- add_shift  out  1  adder shift
- add_subtract  out  1  adder subtract
- add_phase  out  4  adder showFluffyPonies; 4'd8 = hold

## Operation
States: IDLE, INIT, ADD_A, ADD_M, SHIFT, RED, SUB, FIN.

- **IDLE**
  - start=1: latch b_in into shift register bsr, clear iteration counter it, clear pass counter pc, go to INIT.
- **INIT** (1 cycle)
  - add_clear_n=0; go to ADD_A.
- **ADD_A**
  - add_enable_c=1; opsel = bsr[0] ? 01 : 00.
  - Go to ADD_M.
- **ADD_M**
  - If c_zero=1: add_enable_c=1, opsel=10.
  - Else: add_enable_c=0, opsel=00.
  - Go to SHIFT.
- **SHIFT**
  - add_shift=1; bsr >>= 1; it += 1.
  - If it==N_BITS-1 before the increment: clear the phase counter ph and go to RED.
  - Otherwise go to ADD_A.
- **RED**
  - add_subtract=0; add_phase=ph; ph steps 0..5.
  - After ph=5: ph=0, go to SUB.
- **SUB**
  - add_subtract=1; add_phase=ph; opsel=11; ph steps 0..5.
  - At ph=5:
    - sub_done=1: go to FIN.
    - Else if pc==MAX_PASS-1: set err flag, go to FIN.
    - Else: pc += 1, ph=0, stay in SUB.
- **FIN** (1 cycle)
  - done=1; err=flag; go to IDLE.
- Result validity:
  - The adder copies the last non-negative result into its accumulator at each SUB ph=0.
  - The result is valid from the cycle done is high until the next start.
- add_phase=4'd8 in every state except RED/SUB. This freezes the adder pipeline registers.
- Unused strobes are 0. opsel=00 outside ADD_A/ADD_M/SUB.
- start while busy is ignored and does not queue.
- sub_done is ignored outside SUB ph=5.

## Timing
- All outputs are registered-state decodes (Moore).
- Reset values: state IDLE, busy=0, done=0, err=0, opsel=00, add_clear_n=1, add_enable_c=0, add_shift=0, add_subtract=0, add_phase=4'd8, bsr=0, it=0, pc=0, ph=0.
- resetn low mid-operation: return to IDLE next edge with all the values above. No done is issued.
- Latency:
  - Start sampled at cycle t; INIT at t+1.
  - Iterations occupy t+2..t+1+3·N_BITS.
  - RED takes 6 cycles; SUB takes 6·P cycles, where P = passes run.
  - done at t+8+3·N_BITS+6·P.
- Next start is accepted in the cycle after FIN (IDLE). Back-to-back throughput = latency+1.
- Counters:
  - it is 10 bits and compares against N_BITS-1, so there is no wrap at 512.
  - pc saturates at MAX_PASS-1.

## Test plan
- Reset: hold resetn=0 for 3 cycles with start=1 → all outputs at reset values; busy=0, add_phase=8.
- N_BITS=4, b_in=4'b0101, c_zero=0 throughout, sub_done=1 at first SUB ph=5 → opsel sequence per iteration 01/00/00, 00/00/00, 01/00/00, 00/00/00; add_enable_c never high in ADD_M; done at t+26, err=0.
- N_BITS=4, b_in=0, c_zero=1 in every ADD_M → add_enable_c=1 with opsel=10 in all 4 ADD_M cycles; add_shift high 4 times, exactly 3 cycles apart.
- N_BITS=4, sub_done=1 only on the third pass → add_phase 0..5 repeated 3 times with add_subtract=1; done at t+38, err=0.
- N_BITS=4, sub_done never asserted → 8 passes, then done with err=1 at t+68.
- Drop resetn during RED, then start again with N_BITS=512 → immediate IDLE with no done; second run gives done at t+1550 (P=1); start pulses during busy are ignored.

Source files
------------

// File: rtl/mont_seq_if.sv
// Handshake and adder-control bundle between the Montgomery sequencer and its
// surroundings. The master side issues start/b_in and reflects the adder flags
// (c_zero, sub_done). The slave side is the sequencer, which drives status and
// every adder control strobe.
interface mont_seq_if;
    logic         start;
    logic [511:0] b_in;
    logic         c_zero;
    logic         sub_done;
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   opsel;
    logic         add_clear_n;
    logic         add_enable_c;
    logic         add_shift;
    logic         add_subtract;
    logic [3:0]   add_phase;

    modport master (
        output start, b_in, c_zero, sub_done,
        input  busy, done, err, opsel, add_clear_n, add_enable_c,
               add_shift, add_subtract, add_phase
    );

    modport slave (
        input  start, b_in, c_zero, sub_done,
        output busy, done, err, opsel, add_clear_n, add_enable_c,
               add_shift, add_subtract, add_phase
    );
endinterface

// File: rtl/mont_seq.sv
// Sequencer for the 514-bit carry-save Montgomery adder. It runs N_BITS
// bit-serial iterations (add A, conditionally add M, shift), then a six-phase
// carry-propagate reduction, then six-phase subtraction passes of M until the
// adder reports underflow or MAX_PASS passes are used up.
// All outputs are registered: the next-state logic also decodes the outputs
// of the state being entered, so each output is a flop.
module mont_seq #(
    parameter int N_BITS   = 512,
    parameter int MAX_PASS = 8
) (
    input  logic        clk,
    input  logic        resetn,
    mont_seq_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ADD_A = 3'd2,
        S_ADD_M = 3'd3,
        S_SHIFT = 3'd4,
        S_RED   = 3'd5,
        S_SUB   = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    localparam int              PC_W       = (MAX_PASS > 1) ? $clog2(MAX_PASS) : 1;
    localparam logic [9:0]      LAST_IT    = 10'(N_BITS - 1);
    localparam logic [PC_W-1:0] LAST_PASS  = PC_W'(MAX_PASS - 1);
    localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);
    localparam logic [2:0]      LAST_PH    = 3'd5;
    localparam logic [3:0]      PHASE_HOLD = 4'd8;

    // State and datapath registers
    state_t            state_r, state_s;
    logic [511:0]      bsr_r, bsr_s;
    logic [9:0]        it_r, it_s;
    logic [PC_W-1:0]   pc_r, pc_s;
    logic [2:0]        ph_r, ph_s;
    logic              err_flag_r, err_flag_s;

    // Registered outputs
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic [1:0]        opsel_r, opsel_s;
    logic              clear_n_r, clear_n_s;
    logic              enable_c_r, enable_c_s;
    logic              shift_r, shift_s;
    logic              subtract_r, subtract_s;
    logic [3:0]        phase_r, phase_s;

    // Next state and counter updates; sub_done only matters at SUB ph=5.
    always_comb begin
        state_s    = state_r;
        bsr_s      = bsr_r;
        it_s       = it_r;
        pc_s       = pc_r;
        ph_s       = ph_r;
        err_flag_s = err_flag_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_s    = S_INIT;
                    bsr_s      = bus.b_in;
                    it_s       = 10'd0;
                    pc_s       = '0;
                    ph_s       = 3'd0;
                    err_flag_s = 1'b0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_INIT:  state_s = S_ADD_A;
            S_ADD_A: state_s = S_ADD_M;
            S_ADD_M: state_s = S_SHIFT;
            S_SHIFT: begin
                bsr_s = {1'b0, bsr_r[511:1]};
                it_s  = it_r + 10'd1;
                if (it_r == LAST_IT) begin
                    ph_s    = 3'd0;
                    state_s = S_RED;
                end else begin
                    state_s = S_ADD_A;
                end
            end
            S_RED: begin
                if (ph_r == LAST_PH) begin
                    ph_s    = 3'd0;
                    state_s = S_SUB;
                end else begin
                    ph_s = ph_r + 3'd1;
                end
            end
            S_SUB: begin
                if (ph_r == LAST_PH) begin
                    ph_s = 3'd0;
                    if (bus.sub_done) begin
                        state_s = S_FIN;
                    end else if (pc_r == LAST_PASS) begin
                        err_flag_s = 1'b1;
                        state_s    = S_FIN;
                    end else begin
                        pc_s = pc_r + PC_ONE;
                    end
                end else begin
                    ph_s = ph_r + 3'd1;
                end
            end
            S_FIN:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Output values for the state being entered, so they can be registered.
    always_comb begin
        busy_s     = (state_s != S_IDLE);
        done_s     = 1'b0;
        err_s      = 1'b0;
        opsel_s    = 2'b00;
        clear_n_s  = 1'b1;
        enable_c_s = 1'b0;
        shift_s    = 1'b0;
        subtract_s = 1'b0;
        phase_s    = PHASE_HOLD;
        case (state_s)
            S_IDLE:  busy_s = 1'b0;
            S_INIT:  clear_n_s = 1'b0;
            S_ADD_A: begin
                enable_c_s = 1'b1;
                opsel_s    = bsr_s[0] ? 2'b01 : 2'b00;
            end
            S_ADD_M: begin
                if (bus.c_zero) begin
                    enable_c_s = 1'b1;
                    opsel_s    = 2'b10;
                end else begin
                    enable_c_s = 1'b0;
                    opsel_s    = 2'b00;
                end
            end
            S_SHIFT: shift_s = 1'b1;
            S_RED:   phase_s = {1'b0, ph_s};
            S_SUB: begin
                subtract_s = 1'b1;
                phase_s    = {1'b0, ph_s};
                opsel_s    = 2'b11;
            end
            S_FIN: begin
                done_s = 1'b1;
                err_s  = err_flag_s;
            end
            default: busy_s = 1'b0;
        endcase
    end

    // Single state register bank with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= S_IDLE;
            bsr_r      <= 512'd0;
            it_r       <= 10'd0;
            pc_r       <= '0;
            ph_r       <= 3'd0;
            err_flag_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            opsel_r    <= 2'b00;
            clear_n_r  <= 1'b1;
            enable_c_r <= 1'b0;
            shift_r    <= 1'b0;
            subtract_r <= 1'b0;
            phase_r    <= PHASE_HOLD;
        end else begin
            state_r    <= state_s;
            bsr_r      <= bsr_s;
            it_r       <= it_s;
            pc_r       <= pc_s;
            ph_r       <= ph_s;
            err_flag_r <= err_flag_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            err_r      <= err_s;
            opsel_r    <= opsel_s;
            clear_n_r  <= clear_n_s;
            enable_c_r <= enable_c_s;
            shift_r    <= shift_s;
            subtract_r <= subtract_s;
            phase_r    <= phase_s;
        end
    end

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.err          = err_r;
    assign bus.opsel        = opsel_r;
    assign bus.add_clear_n  = clear_n_r;
    assign bus.add_enable_c = enable_c_r;
    assign bus.add_shift    = shift_r;
    assign bus.add_subtract = subtract_r;
    assign bus.add_phase    = phase_r;
endmodule
